// File: rtl/ram_responder.sv
// Word-addressed RAM model that answers a level-held read/write request after a
// fixed number of BUSY cycles, reporting FREE/BUSY/ACCESS/ERROR as its state.
package caches_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

// state  | meaning
// FREE   | idle, evaluating the request inputs
// BUSY   | valid request latched, counting down the access latency
// ACCESS | one-cycle completion: write committed / ramload valid
// ERROR  | invalid request present (both ops, misaligned or out of range)
module ram_responder
  import caches_pkg::*;
#(
  parameter int LAT   = 2,
  parameter int DEPTH = 1024
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      ramREN,
  input  logic      ramWEN,
  input  word_t     ramaddr,
  input  word_t     ramstore,
  output word_t     ramload,
  output ramstate_t ramstate
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [3:0]  LAT4       = 4'(LAT);
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) << 2;

  ramstate_t  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       wr_q, wr_d;
  word_t      addr_q, addr_d;
  word_t      data_q, data_d;
  word_t      load_q;
  word_t      mem_q [DEPTH];

  logic         req;
  logic         valid;
  logic         changed;
  logic         access_en;
  logic [AW-1:0] idx_d;

  assign req     = ramREN | ramWEN;
  assign valid   = (ramREN ^ ramWEN) && (ramaddr[1:0] == 2'b00) &&
                   ({1'b0, ramaddr} < ADDR_LIMIT);
  // Store data only matters for a write; a read ignores ramstore changes.
  assign changed = (ramaddr != addr_q) || (ramWEN != wr_q) ||
                   (ramWEN && (ramstore != data_q));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      BUSY: begin
        if (!req) begin
          state_d = FREE;
        end else if (!valid) begin
          state_d = ERROR;
        end else if (changed) begin
          wr_d   = ramWEN;
          addr_d = ramaddr;
          data_d = ramstore;
          cnt_d  = LAT4;
        end else if (cnt_q <= 4'd1) begin
          state_d = ACCESS;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        if (valid) begin
          wr_d   = ramWEN;
          addr_d = ramaddr;
          data_d = ramstore;
          if (LAT4 == 4'd0) begin
            state_d = ACCESS;
            cnt_d   = 4'd0;
          end else begin
            state_d = BUSY;
            cnt_d   = LAT4;
          end
        end else if (req) begin
          state_d = ERROR;
        end else begin
          state_d = FREE;
        end
      end
    endcase
  end

  // The access uses next-state latches so LAT==0 (FREE -> ACCESS) sees the live request.
  assign access_en = (state_d == ACCESS);
  assign idx_d     = addr_d[AW+1:2];

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= FREE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      if (access_en && !wr_d) begin
        load_q <= mem_q[idx_d];
      end
    end
  end

  // Memory has no reset; a write is blocked while nRST is low.
  always_ff @(posedge CLK) begin
    if (nRST && access_en && wr_d) begin
      mem_q[idx_d] <= data_d;
    end
  end

  assign ramload  = load_q;
  assign ramstate = state_q;

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder (LAT=2, DEPTH=1024) with a read-data scoreboard
// fed from a small memory model.
module tb_ram_responder;
  import caches_pkg::*;

  logic      CLK = 1'b0;
  logic      nRST;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  int    n_chk  = 0;
  int    n_pass = 0;
  word_t model [int];
  word_t exp_q [$];

  ram_responder #(.LAT(2), .DEPTH(1024)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_state(input ramstate_t exp, input string tag);
    n_chk++;
    assert (ramstate === exp) n_pass++;
    else $error("FAIL %s: ramstate got %0d expected %0d", tag, ramstate, exp);
  endtask

  task automatic chk_load(input word_t exp, input string tag);
    n_chk++;
    assert (ramload === exp) n_pass++;
    else $error("FAIL %s: ramload got %08h expected %08h", tag, ramload, exp);
  endtask

  task automatic step(input ramstate_t exp, input string tag);
    tick();
    chk_state(exp, tag);
  endtask

  // Pop the expected read data when the DUT reaches ACCESS.
  task automatic pop_read(input string tag);
    word_t exp;
    if (exp_q.size() == 0) begin
      n_chk++;
      $error("FAIL %s: scoreboard empty at ACCESS", tag);
    end else begin
      exp = exp_q.pop_front();
      chk_load(exp, tag);
    end
  endtask

  task automatic do_write(input word_t a, input word_t d, input string tag);
    ramREN = 1'b0; ramWEN = 1'b1; ramaddr = a; ramstore = d;
    step(BUSY,   {tag, "_b1"});
    step(BUSY,   {tag, "_b2"});
    step(ACCESS, {tag, "_acc"});
    model[int'(a >> 2)] = d;
    ramWEN = 1'b0;
    step(FREE,   {tag, "_free"});
  endtask

  task automatic do_read(input word_t a, input string tag);
    ramREN = 1'b1; ramWEN = 1'b0; ramaddr = a;
    exp_q.push_back(model[int'(a >> 2)]);
    step(BUSY,   {tag, "_b1"});
    step(BUSY,   {tag, "_b2"});
    step(ACCESS, {tag, "_acc"});
    pop_read({tag, "_data"});
    ramREN = 1'b0;
    step(FREE,   {tag, "_free"});
  endtask

  initial begin
    // reset held with a read request present
    nRST = 1'b0; ramREN = 1'b1; ramWEN = 1'b0; ramaddr = 32'h0; ramstore = 32'h0;
    step(FREE, "rst1"); chk_load(32'h0, "rst1_load");
    step(FREE, "rst2"); chk_load(32'h0, "rst2_load");
    nRST = 1'b1;
    step(BUSY,   "rel_b1");
    step(BUSY,   "rel_b2");
    step(ACCESS, "rel_acc");
    ramREN = 1'b0;
    step(FREE,   "rel_free");

    // write then read back
    do_write(32'h40, 32'hDEADBEEF, "wr40");
    do_read(32'h40, "rd40");

    // abort after one BUSY cycle leaves ramload alone
    ramREN = 1'b1; ramaddr = 32'h80;
    step(BUSY, "abort_b1");
    ramREN = 1'b0;
    step(FREE, "abort_free");
    chk_load(32'hDEADBEEF, "abort_load");

    // restart on address change
    do_write(32'h80, 32'h80808080, "wr80");
    do_write(32'h84, 32'hCAFE0084, "wr84");
    chk_load(32'hDEADBEEF, "wr_keeps_load");
    ramREN = 1'b1; ramaddr = 32'h80;
    step(BUSY, "rs_b0");
    ramaddr = 32'h84;
    exp_q.push_back(model[32'h84 >> 2]);
    step(BUSY,   "rs_b1");
    step(BUSY,   "rs_b2");
    step(ACCESS, "rs_acc");
    pop_read("rs_data");
    ramREN = 1'b0;
    step(FREE, "rs_free");

    // back-to-back reads with no FREE gap
    do_write(32'h44, 32'h44444444, "wr44");
    ramREN = 1'b1; ramaddr = 32'h40;
    exp_q.push_back(model[32'h40 >> 2]);
    step(BUSY,   "bb_b1");
    step(BUSY,   "bb_b2");
    step(ACCESS, "bb_acc1");
    pop_read("bb_data1");
    ramaddr = 32'h44;
    exp_q.push_back(model[32'h44 >> 2]);
    step(BUSY,   "bb_b3");
    step(BUSY,   "bb_b4");
    step(ACCESS, "bb_acc2");
    pop_read("bb_data2");
    ramREN = 1'b0;
    step(FREE, "bb_free");

    // error cases
    ramREN = 1'b1; ramWEN = 1'b1; ramaddr = 32'h40; ramstore = 32'h12345678;
    step(ERROR, "err_both1");
    step(ERROR, "err_both2");
    ramREN = 1'b0; ramWEN = 1'b0;
    step(FREE, "err_both_free");
    ramREN = 1'b1; ramaddr = 32'h42;
    step(ERROR, "err_misalign");
    ramREN = 1'b0;
    step(FREE, "err_mis_free");
    ramREN = 1'b1; ramaddr = 32'h1000;
    step(ERROR, "err_range");
    chk_load(32'h44444444, "err_keeps_load");
    ramaddr = 32'h40;
    exp_q.push_back(model[32'h40 >> 2]);
    step(BUSY,   "err_exit_b1");
    step(BUSY,   "err_exit_b2");
    step(ACCESS, "err_exit_acc");
    pop_read("err_mem_intact");
    ramREN = 1'b0;
    step(FREE, "err_exit_free");

    // highest legal word
    do_write(32'hFFC, 32'h0BADF00D, "wrtop");
    do_read(32'hFFC, "rdtop");

    // reset in the middle of a write
    do_write(32'h10, 32'h10101010, "wr10");
    ramWEN = 1'b1; ramaddr = 32'h10; ramstore = 32'h55AA55AA;
    step(BUSY, "rw_b1");
    nRST = 1'b0;
    step(FREE, "rw_rst");
    chk_load(32'h0, "rw_rst_load");
    nRST = 1'b1; ramWEN = 1'b0;
    step(FREE, "rw_idle");
    do_read(32'h10, "rw_rd10");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
